// File: rtl/hs_sync_tx.sv
// rtl/hs_sync_tx.sv - toggle-handshake transmitter with ack synchroniser, timeout and drop counter
//
// Sends a DW-bit payload to an asynchronous receiver using a req/ack toggle
// handshake. Each accepted send inverts req_out. The transfer completes once
// the synchronised ack_in equals req_out. If no ack arrives within TIMEOUT
// WAIT_ACK cycles, the block latches an error until reset.
//
// Ports:
//   clk_tx    in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   send      in   transfer request, sampled every cycle
//   din       in   payload, captured when send is accepted
//   ack_in    in   receiver ack toggle (asynchronous)
//   req_out   out  request toggle to the receiver (registered)
//   dout      out  payload to the receiver (registered, stable while busy)
//   busy      out  transfer outstanding or error latched
//   done      out  one-cycle completion pulse
//   err       out  sticky timeout flag
//   drop_cnt  out  saturating count of rejected send pulses

module hs_sync_tx #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk_tx,
  input  logic          rst,
  input  logic          send,
  input  logic [DW-1:0] din,
  input  logic          ack_in,
  output logic          req_out,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    drop_cnt
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] ack_sh;
  logic                   ack_sync;
  logic [TW-1:0]          timer, timer_nxt;
  logic                   req_nxt;
  logic [DW-1:0]          dout_nxt;
  logic                   done_nxt;
  logic [7:0]             drop_nxt;

  // ack_in is only ever read by the first flop of this chain
  always_ff @(posedge clk_tx) begin
    if (rst) begin
      ack_sh <= '0;
    end else begin
      ack_sh <= {ack_sh[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign ack_sync = ack_sh[SYNC_STAGES-1];

  always_ff @(posedge clk_tx) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      req_out  <= 1'b0;
      dout     <= '0;
      done     <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      req_out  <= req_nxt;
      dout     <= dout_nxt;
      done     <= done_nxt;
      drop_cnt <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    req_nxt   = req_out;
    dout_nxt  = dout;
    done_nxt  = 1'b0;
    drop_nxt  = drop_cnt;

    // Any send outside IDLE is rejected and counted
    if (send && (state != IDLE) && (drop_cnt != 8'hFF)) begin
      drop_nxt = drop_cnt + 8'd1;
    end

    case (state)
      IDLE: begin
        if (send) begin
          dout_nxt  = din;
          req_nxt   = ~req_out;
          timer_nxt = '0;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Completion is tested first so it wins over a same-edge timeout
        if (ack_sync == req_out) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (timer == TW'(TIMEOUT)) begin
          state_nxt = ERR;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ERR: begin
        // Held until reset; req_out and dout keep their values
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign err  = (state == ERR);

endmodule
